// File: rtl/ber_ctrl.sv
// BER measurement sequencer: clears the BER counter, waits for it to lock
// (first nonzero bit count), measures a window of bits or until stopped, then
// latches the counter values into the result registers.
module ber_ctrl #(
  parameter int unsigned REG_LEN  = 64,
  parameter int unsigned WIN_W    = 32,
  parameter int unsigned ADAPT_TO = 1100000,
  parameter int unsigned CLR_CYC  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               cmd_start,
  input  logic               cmd_stop,
  input  logic [WIN_W-1:0]   window_len,
  input  logic [REG_LEN-1:0] ber_error_count,
  input  logic [REG_LEN-1:0] ber_bit_count,
  output logic               ber_rst_n,
  output logic               ber_enable,
  output logic               busy,
  output logic               done,
  output logic               done_pulse,
  output logic               timeout,
  output logic               aborted,
  output logic [REG_LEN-1:0] result_errors,
  output logic [REG_LEN-1:0] result_bits,
  output logic [2:0]         state
);

  localparam int unsigned AdaptW = $clog2(ADAPT_TO + 1);
  localparam int unsigned ClrW   = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam int unsigned CmpW   = (REG_LEN > WIN_W) ? REG_LEN : WIN_W;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StAdapt = 3'd2,
    StRun   = 3'd3,
    StLatch = 3'd4,
    StDone  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [ClrW-1:0]    clr_cnt_q, clr_cnt_d;
  logic [AdaptW-1:0]  adapt_cnt_q, adapt_cnt_d;
  logic               timeout_q, timeout_d;
  logic               aborted_q, aborted_d;
  logic               done_pulse_q, done_pulse_d;
  logic [REG_LEN-1:0] res_err_q, res_err_d;
  logic [REG_LEN-1:0] res_bits_q, res_bits_d;

  logic [CmpW-1:0]    win_ext;
  logic [CmpW-1:0]    bits_ext;
  logic               win_hit;
  logic               adapt_limit;

  // Window compare done at the wider of the two widths, zero-extended.
  always_comb begin
    win_ext     = CmpW'(win_q);
    bits_ext    = CmpW'(ber_bit_count);
    win_hit     = (win_q != '0) && (bits_ext >= win_ext);
    adapt_limit = (adapt_cnt_q == AdaptW'(ADAPT_TO));
  end

  // Next-state and register updates for the measurement sequence.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    clr_cnt_d   = clr_cnt_q;
    adapt_cnt_d = adapt_cnt_q;
    timeout_d   = timeout_q;
    aborted_d   = aborted_q;
    res_err_d   = res_err_q;
    res_bits_d  = res_bits_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (cmd_start) begin
          state_d     = StClear;
          win_d       = window_len;
          timeout_d   = 1'b0;
          aborted_d   = 1'b0;
          clr_cnt_d   = '0;
          adapt_cnt_d = '0;
        end
      end
      StClear: begin
        if (clr_cnt_q == ClrW'(CLR_CYC - 1)) begin
          state_d = StAdapt;
        end else begin
          clr_cnt_d = clr_cnt_q + ClrW'(1);
        end
      end
      StAdapt: begin
        // Saturate so a strobe in the exit cycle cannot wrap the counter.
        if (valid && !adapt_limit) begin
          adapt_cnt_d = adapt_cnt_q + AdaptW'(1);
        end
        if (cmd_stop) begin
          state_d   = StLatch;
          aborted_d = 1'b1;
        end else if (ber_bit_count != '0) begin
          state_d = StRun;
        end else if (adapt_limit) begin
          state_d    = StDone;
          timeout_d  = 1'b1;
          res_err_d  = '0;
          res_bits_d = '0;
        end
      end
      StRun: begin
        if (cmd_stop) begin
          state_d   = StLatch;
          aborted_d = 1'b1;
        end else if (win_hit) begin
          state_d = StLatch;
        end
      end
      StLatch: begin
        res_err_d  = ber_error_count;
        res_bits_d = ber_bit_count;
        state_d    = StDone;
      end
      default: state_d = StIdle;
    endcase
    done_pulse_d = (state_d == StDone) && (state_q != StDone);
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      win_q        <= '0;
      clr_cnt_q    <= '0;
      adapt_cnt_q  <= '0;
      timeout_q    <= 1'b0;
      aborted_q    <= 1'b0;
      done_pulse_q <= 1'b0;
      res_err_q    <= '0;
      res_bits_q   <= '0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      clr_cnt_q    <= clr_cnt_d;
      adapt_cnt_q  <= adapt_cnt_d;
      timeout_q    <= timeout_d;
      aborted_q    <= aborted_d;
      done_pulse_q <= done_pulse_d;
      res_err_q    <= res_err_d;
      res_bits_q   <= res_bits_d;
    end
  end

  // Counter controls decoded from state; gated by rst so the BER counter
  // stops in the very cycle reset is asserted.
  always_comb begin
    ber_rst_n  = rst && ((state_q == StAdapt) || (state_q == StRun) || (state_q == StLatch));
    ber_enable = rst && ((state_q == StAdapt) || ((state_q == StRun) && !win_hit));
    busy       = (state_q == StClear) || (state_q == StAdapt) ||
                 (state_q == StRun) || (state_q == StLatch);
    done       = (state_q == StDone);
  end

  assign done_pulse    = done_pulse_q;
  assign timeout       = timeout_q;
  assign aborted       = aborted_q;
  assign result_errors = res_err_q;
  assign result_bits   = res_bits_q;
  assign state         = state_q;

endmodule

// File: doc/ber_ctrl.md
BER_CTRL -- requirements
Module: ber_ctrl

Interface
REQ-001 Parameter REG_LEN, default 64: width of the BER counters and result registers.
REQ-002 Parameter WIN_W, default 32: width of window_len.
REQ-003 Parameter ADAPT_TO, default 1100000: maximum number of valid strobes allowed in ADAPT (greater than 1022*1023); adapt counter is clog2(ADAPT_TO+1) bits.
REQ-004 Parameter CLR_CYC, default 2: number of cycles ber_rst_n is held low in CLEAR.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 valid  in  1  symbol strobe, the same strobe that feeds the BER counter.
REQ-008 cmd_start  in  1  one-cycle request to begin a measurement.
REQ-009 cmd_stop  in  1  one-cycle request to abort a running measurement.
REQ-010 window_len  in  WIN_W  number of bits to measure; 0 means run until cmd_stop.
REQ-011 ber_error_count  in  REG_LEN  error count from the BER counter.
REQ-012 ber_bit_count  in  REG_LEN  bit count from the BER counter.
REQ-013 ber_rst_n  out  1  active-low clear driven to the BER counter.
REQ-014 ber_enable  out  1  enable driven to the BER counter.
REQ-015 busy  out  1  high in CLEAR, ADAPT, RUN and LATCH.
REQ-016 done  out  1  high in DONE.
REQ-017 done_pulse  out  1  one-cycle pulse on entry to DONE.
REQ-018 timeout  out  1  the last measurement ended on adaptation timeout.
REQ-019 aborted  out  1  the last measurement ended on cmd_stop.
REQ-020 result_errors  out  REG_LEN  latched error count.
REQ-021 result_bits  out  REG_LEN  latched bit count.
REQ-022 state  out  3  encoding: IDLE=0, CLEAR=1, ADAPT=2, RUN=3, LATCH=4, DONE=5.

Function
REQ-023 IDLE or DONE, cmd_start=1 -> CLEAR next cycle: window_len latched into win_reg; timeout, aborted and the clear/adapt counters cleared; result_* held.
REQ-024 cmd_start in any other state is ignored; cmd_stop in IDLE, CLEAR, LATCH or DONE is ignored.
REQ-025 CLEAR: ber_rst_n=0 for exactly CLR_CYC cycles, then -> ADAPT.
REQ-026 ADAPT: ber_rst_n=1 and ber_enable=1; adapt counter increments on each valid=1.
REQ-027 ADAPT exits in this priority: cmd_stop -> LATCH with aborted=1; ber_bit_count!=0 -> RUN; adapt counter==ADAPT_TO -> DONE with timeout=1 and result_* cleared to 0.
REQ-028 RUN: win_hit = (win_reg!=0) and (ber_bit_count >= win_reg), zero-extended compare.
REQ-029 ber_enable is combinational: 1 in ADAPT; in RUN it is the inverse of win_hit; 0 in all other states. result_bits therefore equals win_reg exactly on a window finish.
REQ-030 RUN exits: cmd_stop -> LATCH with aborted=1 (takes priority if win_hit is also true); win_hit -> LATCH.
REQ-031 LATCH (one cycle): ber_rst_n=1, ber_enable=0, result_errors<=ber_error_count, result_bits<=ber_bit_count; -> DONE.
REQ-032 DONE: ber_rst_n=0, ber_enable=0; result_*, timeout and aborted held until the next cmd_start.
REQ-033 ber_rst_n is 0 in IDLE, CLEAR and DONE, and 1 in ADAPT, RUN and LATCH.
REQ-034 done_pulse=1 only in the first cycle of DONE.

Reset
REQ-035 rst=0 at a clock edge, in any state: state=IDLE, ber_rst_n=0, ber_enable=0, busy=0, done=0, done_pulse=0, timeout=0, aborted=0, result_errors=0, result_bits=0, and all internal counters and win_reg cleared.
REQ-036 cmd_start and cmd_stop are ignored while rst=0.

Verification
REQ-037 Reset: rst=0 for 2 cycles -> state=0, ber_rst_n=0, ber_enable=0, busy=0, done=0, results=0.
REQ-038 Normal run: window_len=1000, stub ber_bit_count rises at the 50th valid strobe -> CLEAR lasts 2 cycles; state passes ADAPT, RUN, LATCH, DONE; result_bits=1000; done_pulse lasts 1 cycle; timeout=0 and aborted=0.
REQ-039 Timeout: ADAPT_TO=100, ber_bit_count held at 0 -> DONE after the 100th valid strobe in ADAPT; timeout=1; results=0; RUN is never entered.
REQ-040 Abort: window_len=1000, cmd_stop when ber_bit_count=300 and ber_error_count=7 -> LATCH, then DONE; result_bits=300, result_errors=7, aborted=1.
REQ-041 Start/stop corners: cmd_start during RUN is ignored; cmd_stop in IDLE is ignored; window_len=0 runs past bit_count 10^6 until cmd_stop; cmd_start in DONE restarts the sequence and clears timeout and aborted.
REQ-042 Mid-run reset: rst=0 during RUN -> state=IDLE and results=0 on the next edge; ber_enable=0 in the same cycle.
